serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: computes diff = a - b, LSB first, one bit per clock.
//  Each bit is processed by a full-subtractor cell (difference/borrow) with a registered borrow.
//  Sits beside the combinational adder cells as the area-cheap inverse (subtract) datapath.
//  Uses a start/busy/done handshake toward a host controller.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend, captured on the accepted start
//  b           in   WIDTH  subtrahend, captured on the accepted start
//  busy        out  1      high while in SHIFT
//  done        out  1      one-cycle pulse; result valid
//  diff        out  WIDTH  a - b mod 2^WIDTH, held until next accepted start
//  borrow_out  out  1      1 iff unsigned a < b, held with diff
//  overflow    out  1      signed overflow; present only with SUB_OVERFLOW_EN
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy, done, borrow_out, overflow = 0;
//   diff = 0; internal shift regs, borrow reg and bit counter = 0.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : start=1 -> load a_sr=a, b_sr=b, br=0, cnt=0; go SHIFT. start=0 -> stay.
//   SHIFT: per cycle: d = a_sr[0]^b_sr[0]^br;
//          br_n = (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & br);
//          shift a_sr, b_sr right by 1; shift d into diff MSB (diff >> 1);
//          br <= br_n; cnt <= cnt+1; after the WIDTH-th bit (cnt==WIDTH-1) go DONE.
//   DONE : done=1 for exactly this cycle; borrow_out = final br; go IDLE unconditionally.
//  Latency: start accepted at edge T -> busy=1 for cycles T+1..T+WIDTH, done=1 in cycle T+WIDTH+1.
//   Next start is accepted no earlier than the cycle after done (throughput WIDTH+2 cycles).
//  start while in SHIFT or DONE: ignored, no effect on the operation in flight; a and b are
//   don't-care outside the accepting cycle.
//  diff bits are not valid while busy (partial shift); diff/borrow_out are stable from the
//   done cycle until the next accepted start, when diff is cleared to 0 and borrow_out to 0.
//  cnt width = $clog2(WIDTH); no wrap is reachable (terminates at WIDTH-1).
//  Reset asserted mid-operation: abort immediately, all outputs to reset values, no done pulse.
//  a == b: diff = 0, borrow_out = 0. Equal-width arithmetic only; no sign extension.
// CONFIGURATION
//  SUB_OVERFLOW_EN defined: overflow port exists; on the last SHIFT bit (MSB),
//   overflow <= (a_sr[0]^b_sr[0]) & (d^a_sr[0]); held with diff; cleared on reset/next start.
//  SUB_OVERFLOW_EN undefined: overflow port and its logic absent; all else identical.
// TESTING (WIDTH=8)
//  a=0x5A, b=0x3C, start 1 cycle -> busy 8 cycles, done at T+9; diff=0x1E, borrow_out=0, ovf=0.
//  a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, overflow=0 (when enabled).
//  a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1 (when enabled); a=0x7F,b=0xFF -> 0x80, ovf=1.
//  start pulsed again with a=0xFF,b=0x00 at T+3 and in the DONE cycle -> ignored; result of first op kept.
//  rst_n low at T+4 of an op -> outputs 0 at once, no done pulse; new op after release completes normally.
//  start held high continuously, a=0x10,b=0x01 -> ops every 10 cycles, each diff=0x0F, done 1-cycle pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Optional signed-overflow output is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
    output logic             borrow_out,
    output logic             overflow
`else
    output logic             borrow_out
`endif
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
    logic               ovf_q, ovf_d;
`endif

    logic d_bit, br_n, last_bit;

    // Full-subtractor cell on the current LSBs, chained through the registered borrow.
    assign d_bit    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    assign br_n     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    diff_d   = '0;
                    cnt_d    = '0;
                    br_d     = 1'b0;
                    borrow_d = 1'b0;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                br_d   = br_n;
                if (last_bit) begin
                    // Publish the final borrow together with the completed diff.
                    borrow_d = br_n;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = (a_sr_q[0] ^ b_sr_q[0]) & (d_bit ^ a_sr_q[0]);
`endif
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); covers overflow when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
`ifdef SUB_OVERFLOW_EN
        .borrow_out (borrow_out),
        .overflow   (overflow)
`else
        .borrow_out (borrow_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef SUB_OVERFLOW_EN
        check(tag, {31'd0, overflow}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    // Runs one operation from IDLE and checks timing plus result.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int cyc;
        int nbusy;
        start = 1'b1; a = av; b = bv;
        tick();
        start = 1'b0; a = '0; b = '0;
        check({tag, "_busy_T1"}, {31'd0, busy}, 32'd1);
        cyc = 1; nbusy = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            tick();
            cyc++;
        end
        check({tag, "_done_cycle"}, cyc, 32'd9);
        check({tag, "_busy_count"}, nbusy, 32'd8);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
        check_ovf({tag, "_ovf"}, eo);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_diff_held"}, {24'd0, diff}, {24'd0, ed});
    endtask

    initial begin
        int last_done;
        int ndone;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        check_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;
        tick();

        run_op("op5A3C", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        run_op("op0001", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op("op8001", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("op7FFF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("opEQ",   8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

        // Start pulses during SHIFT and DONE must not disturb the operation in flight.
        start = 1'b1; a = 8'h5A; b = 8'h3C;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00;
        check("ign_cleared", {24'd0, diff}, 32'd0);
        tick(); tick();
        start = 1'b1; a = 8'hFF; b = 8'h00;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("ign_done_T9", {31'd0, done}, 32'd1);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        tick();
        start = 1'b0;
        check("ign_idle", {31'd0, busy}, 32'd0);
        check("ign_diff", {24'd0, diff}, 32'h1E);
        check("ign_borrow", {31'd0, borrow_out}, 32'd0);
        tick();
        check("ign_no_restart", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation.
        start = 1'b1; a = 8'h80; b = 8'h01;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_diff", {24'd0, diff}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        check("arst_no_done", ndone, 32'd0);
        rst_n = 1'b1;
        tick();
        run_op("post_rst", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

        // Continuous start: one operation every WIDTH+2 cycles.
        start = 1'b1; a = 8'h10; b = 8'h01;
        tick();
        ndone = 0; last_done = -1;
        for (int c = 1; c <= 35; c++) begin
            if (done) begin
                ndone++;
                check("cont_diff", {24'd0, diff}, 32'h0F);
                if (last_done >= 0) check("cont_gap", c - last_done, 32'd10);
                else check("cont_first", c, 32'd9);
                last_done = c;
            end
            tick();
        end
        start = 1'b0;
        check("cont_count", ndone, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
